// File: rtl/sprite_line_eval_if.sv
// Sprite write bus, scanline request and per-line slot results between
// the execute stage, the sprite evaluator and the VGA pixel pipeline.
interface sprite_line_eval_if #(
  parameter int MAX_PER_LINE = 4
);
  logic                      sprite_wr;
  logic [4:0]                sprite_sel;
  logic [9:0]                sprite_x;
  logic [8:0]                sprite_y;
  logic                      sprite_vis;
  logic                      sprite_attr;
  logic                      sprite_pos;
  logic                      line_start;
  logic [8:0]                line;
  logic                      eval_busy;
  logic                      eval_done;
  logic                      overflow;
  logic [MAX_PER_LINE-1:0]   slot_valid;
  logic [5*MAX_PER_LINE-1:0] slot_idx;
  logic [10*MAX_PER_LINE-1:0] slot_x;
  logic [4*MAX_PER_LINE-1:0] slot_row;
  logic [MAX_PER_LINE-1:0]   slot_attr;
  logic [MAX_PER_LINE-1:0]   slot_pos;

  modport master (
    output sprite_wr, sprite_sel, sprite_x, sprite_y, sprite_vis, sprite_attr, sprite_pos,
    output line_start, line,
    input  eval_busy, eval_done, overflow, slot_valid, slot_idx, slot_x, slot_row,
    input  slot_attr, slot_pos
  );

  modport slave (
    input  sprite_wr, sprite_sel, sprite_x, sprite_y, sprite_vis, sprite_attr, sprite_pos,
    input  line_start, line,
    output eval_busy, eval_done, overflow, slot_valid, slot_idx, slot_x, slot_row,
    output slot_attr, slot_pos
  );
endinterface

// File: rtl/sprite_line_eval.sv
// Sprite attribute table with a one-entry-per-cycle scanline evaluator that
// collects up to MAX_PER_LINE visible sprites in ascending index order.
module sprite_line_eval #(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_H     = 16
) (
  input logic               clk,
  input logic               reset,
  sprite_line_eval_if.slave bus
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_SPRITES - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_PER_LINE);
  localparam logic [9:0] HEIGHT   = 10'(SPRITE_H);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [9:0] tbl_x_r    [NUM_SPRITES];
  logic [8:0] tbl_y_r    [NUM_SPRITES];
  logic       tbl_vis_r  [NUM_SPRITES];
  logic       tbl_attr_r [NUM_SPRITES];
  logic       tbl_pos_r  [NUM_SPRITES];

  logic [8:0]                  line_r;
  logic [4:0]                  idx_r;
  logic [3:0]                  count_r;
  logic                        overflow_r;
  logic                        eval_busy_r;
  logic                        eval_done_r;
  logic [MAX_PER_LINE-1:0]     slot_valid_r;
  logic [5*MAX_PER_LINE-1:0]   slot_idx_r;
  logic [10*MAX_PER_LINE-1:0]  slot_x_r;
  logic [4*MAX_PER_LINE-1:0]   slot_row_r;
  logic [MAX_PER_LINE-1:0]     slot_attr_r;
  logic [MAX_PER_LINE-1:0]     slot_pos_r;

  logic       start_s;
  logic       fill_s;
  logic       spill_s;
  logic [9:0] diff_s;

  // Table write port; a write to the entry under scan lands after that entry is examined.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_x_r[i]    <= 10'd0;
        tbl_y_r[i]    <= 9'd0;
        tbl_vis_r[i]  <= 1'b0;
        tbl_attr_r[i] <= 1'b0;
        tbl_pos_r[i]  <= 1'b0;
      end
    end else if (bus.sprite_wr && ({1'b0, bus.sprite_sel} < 6'(NUM_SPRITES))) begin
      tbl_x_r[bus.sprite_sel]    <= bus.sprite_x;
      tbl_y_r[bus.sprite_sel]    <= bus.sprite_y;
      tbl_vis_r[bus.sprite_sel]  <= bus.sprite_vis;
      tbl_attr_r[bus.sprite_sel] <= bus.sprite_attr;
      tbl_pos_r[bus.sprite_sel]  <= bus.sprite_pos;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state; line_start outside IDLE is dropped
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.line_start) begin
          state_next_s = ST_SCAN;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Hit test: unsigned 10-bit difference, so sprites above the line never wrap around
  always_comb begin
    diff_s  = {1'b0, line_r} - {1'b0, tbl_y_r[idx_r]};
    fill_s  = 1'b0;
    spill_s = 1'b0;
    if ((state_r == ST_SCAN) && tbl_vis_r[idx_r] && !diff_s[9] && (diff_s < HEIGHT)) begin
      if (count_r < MAX_CNT) begin
        fill_s = 1'b1;
      end else begin
        spill_s = 1'b1;
      end
    end else begin
      fill_s  = 1'b0;
      spill_s = 1'b0;
    end
  end

  // Scan datapath, slot registers and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      line_r       <= 9'd0;
      idx_r        <= 5'd0;
      count_r      <= 4'd0;
      overflow_r   <= 1'b0;
      eval_busy_r  <= 1'b0;
      eval_done_r  <= 1'b0;
      slot_valid_r <= '0;
      slot_idx_r   <= '0;
      slot_x_r     <= '0;
      slot_row_r   <= '0;
      slot_attr_r  <= '0;
      slot_pos_r   <= '0;
    end else begin
      eval_busy_r <= (state_next_s == ST_SCAN);
      eval_done_r <= (state_next_s == ST_DONE);
      if (start_s) begin
        line_r       <= bus.line;
        idx_r        <= 5'd0;
        count_r      <= 4'd0;
        overflow_r   <= 1'b0;
        slot_valid_r <= '0;
        slot_idx_r   <= '0;
        slot_x_r     <= '0;
        slot_row_r   <= '0;
        slot_attr_r  <= '0;
        slot_pos_r   <= '0;
      end else if (state_r == ST_SCAN) begin
        if (idx_r != LAST_IDX) begin
          idx_r <= idx_r + 5'd1;
        end
        for (int k = 0; k < MAX_PER_LINE; k++) begin
          if (fill_s && (count_r == 4'(k))) begin
            slot_valid_r[k]       <= 1'b1;
            slot_idx_r[k*5 +: 5]  <= idx_r;
            slot_x_r[k*10 +: 10]  <= tbl_x_r[idx_r];
            slot_row_r[k*4 +: 4]  <= diff_s[3:0];
            slot_attr_r[k]        <= tbl_attr_r[idx_r];
            slot_pos_r[k]         <= tbl_pos_r[idx_r];
          end
        end
        if (fill_s) begin
          count_r <= count_r + 4'd1;
        end
        if (spill_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  assign bus.eval_busy  = eval_busy_r;
  assign bus.eval_done  = eval_done_r;
  assign bus.overflow   = overflow_r;
  assign bus.slot_valid = slot_valid_r;
  assign bus.slot_idx   = slot_idx_r;
  assign bus.slot_x     = slot_x_r;
  assign bus.slot_row   = slot_row_r;
  assign bus.slot_attr  = slot_attr_r;
  assign bus.slot_pos   = slot_pos_r;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Scoreboard bench for sprite_line_eval: a per-sprite list model predicts each
// scanline's slots; a monitor compares them whenever eval_done pulses.
module tb_sprite_line_eval;

  localparam int N = 32;
  localparam int M = 4;
  localparam int H = 16;

  logic clk = 1'b0;
  logic reset;

  sprite_line_eval_if #(.MAX_PER_LINE(M)) bus ();

  sprite_line_eval #(.NUM_SPRITES(N), .MAX_PER_LINE(M), .SPRITE_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ovf;
    logic [3:0]  valid;
    logic [19:0] idx;
    logic [39:0] x;
    logic [15:0] row;
    logic [3:0]  attr;
    logic [3:0]  pos;
  } result_t;

  result_t exp_q[$];
  int checks = 0;
  int passes = 0;

  int m_x[N], m_y[N];
  bit m_vis[N], m_attr[N], m_pos[N];
  int v_x[N], v_y[N];
  bit v_vis[N], v_attr[N], v_pos[N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference: walk sprites low to high, keep first M that cover the line.
  function automatic result_t predict(input int ln);
    result_t r;
    int n;
    r = '0;
    n = 0;
    for (int s = 0; s < N; s++) begin
      if (v_vis[s] && ln >= v_y[s] && (ln - v_y[s]) < H) begin
        if (n < M) begin
          r.valid[n]        = 1'b1;
          r.idx[n*5 +: 5]   = 5'(s);
          r.x[n*10 +: 10]   = 10'(v_x[s]);
          r.row[n*4 +: 4]   = 4'(ln - v_y[s]);
          r.attr[n]         = v_attr[s];
          r.pos[n]          = v_pos[s];
          n++;
        end else begin
          r.ovf = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    result_t act;
    result_t e;
    if (reset === 1'b0 && bus.eval_done === 1'b1) begin
      check("done_has_pending_expect", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act.ovf   = bus.overflow;
        act.valid = bus.slot_valid;
        act.idx   = bus.slot_idx;
        act.x     = bus.slot_x;
        act.row   = bus.slot_row;
        act.attr  = bus.slot_attr;
        act.pos   = bus.slot_pos;
        check("line_slots", 128'(act), 128'(e));
      end
    end
  end

  task automatic clear_model();
    for (int s = 0; s < N; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_vis[s] = 0; m_attr[s] = 0; m_pos[s] = 0;
    end
  endtask

  task automatic drive_wr(input int sel, input int x, input int y, input bit vis,
                          input bit attr, input bit pos);
    bus.sprite_sel  = 5'(sel);
    bus.sprite_x    = 10'(x);
    bus.sprite_y    = 9'(y);
    bus.sprite_vis  = vis;
    bus.sprite_attr = attr;
    bus.sprite_pos  = pos;
    bus.sprite_wr   = 1'b1;
  endtask

  task automatic wr(input int sel, input int x, input int y, input bit vis,
                    input bit attr, input bit pos);
    drive_wr(sel, x, y, vis, attr, pos);
    m_x[sel] = x; m_y[sel] = y; m_vis[sel] = vis; m_attr[sel] = attr; m_pos[sel] = pos;
    @(posedge clk); #1;
    bus.sprite_wr = 1'b0;
  endtask

  // One scanline request; optional in-scan write, stray line_start, or reset at given cycles.
  task automatic do_line(input int ln, input int wr_cyc, input int ws, input int wx,
                         input int wy, input bit wv, input bit wa, input bit wp,
                         input int dup_cyc, input int rst_cyc);
    int cyc;
    bit done_seen;
    for (int s = 0; s < N; s++) begin
      v_x[s] = m_x[s]; v_y[s] = m_y[s]; v_vis[s] = m_vis[s];
      v_attr[s] = m_attr[s]; v_pos[s] = m_pos[s];
    end
    if (wr_cyc > 0) begin
      m_x[ws] = wx; m_y[ws] = wy; m_vis[ws] = wv; m_attr[ws] = wa; m_pos[ws] = wp;
      // entry ws is examined in cycle ws+1; only an earlier write is visible to it
      if (ws >= wr_cyc) begin
        v_x[ws] = wx; v_y[ws] = wy; v_vis[ws] = wv; v_attr[ws] = wa; v_pos[ws] = wp;
      end
    end
    if (rst_cyc == 0) exp_q.push_back(predict(ln));
    bus.line       = 9'(ln);
    bus.line_start = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    cyc = 1;
    done_seen = 1'b0;
    while (cyc <= N + 8 && !done_seen) begin
      if (cyc == wr_cyc) drive_wr(ws, wx, wy, wv, wa, wp);
      if (cyc == dup_cyc) begin
        bus.line       = 9'(ln + 1);
        bus.line_start = 1'b1;
      end
      if (cyc == rst_cyc) reset = 1'b1;
      @(negedge clk);
      if (cyc == 1) check("busy_first_scan_cycle", 128'(bus.eval_busy), 128'(1));
      if (rst_cyc > 0 && cyc == rst_cyc + 1)
        check("busy_after_reset", 128'(bus.eval_busy), 128'(0));
      if (bus.eval_done === 1'b1) begin
        done_seen = 1'b1;
        check("done_latency", 128'(cyc), 128'(N + 1));
      end
      @(posedge clk); #1;
      bus.sprite_wr  = 1'b0;
      bus.line_start = 1'b0;
      reset          = 1'b0;
      cyc++;
    end
    check("done_seen", 128'(done_seen), 128'(rst_cyc == 0));
    if (rst_cyc > 0) clear_model();
  endtask

  task automatic line_plain(input int ln);
    do_line(ln, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sel, y, ln, wc, dc;
    bus.sprite_wr = 1'b0; bus.sprite_sel = 5'd0; bus.sprite_x = 10'd0; bus.sprite_y = 9'd0;
    bus.sprite_vis = 1'b0; bus.sprite_attr = 1'b0; bus.sprite_pos = 1'b0;
    bus.line_start = 1'b0; bus.line = 9'd0;
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 128'(bus.eval_busy), 128'(0));
    check("reset_done", 128'(bus.eval_done), 128'(0));
    check("reset_overflow", 128'(bus.overflow), 128'(0));
    check("reset_slot_valid", 128'(bus.slot_valid), 128'(0));
    check("reset_slot_idx_x", 128'({bus.slot_idx, bus.slot_x, bus.slot_row}), 128'(0));
    @(posedge clk); #1;

    line_plain(5);
    wr(3, 100, 10, 1'b1, 1'b1, 1'b0);
    line_plain(25);
    line_plain(26);
    line_plain(9);

    wr(0, 11, 50, 1'b1, 1'b0, 1'b1);
    wr(2, 222, 50, 1'b1, 1'b1, 1'b0);
    wr(7, 777, 50, 1'b1, 1'b1, 1'b1);
    wr(9, 999, 50, 1'b1, 1'b0, 1'b0);
    wr(30, 300, 50, 1'b1, 1'b1, 1'b1);
    line_plain(52);
    line_plain(65);
    line_plain(66);

    wr(5, 55, 508, 1'b1, 1'b0, 1'b0);
    wr(6, 66, 2, 1'b0, 1'b1, 1'b1);
    line_plain(2);

    do_line(52, 5, 4, 444, 50, 1'b1, 1'b1, 1'b0, 10, 0);
    line_plain(52);
    do_line(52, 3, 20, 123, 40, 1'b1, 1'b0, 1'b1, 0, 0);

    do_line(52, 0, 0, 0, 0, 0, 0, 0, 0, 15);
    line_plain(52);

    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 6; w++) begin
        sel = $urandom_range(N - 1, 0);
        y = ($urandom_range(9, 0) == 0) ? $urandom_range(511, 500) : $urandom_range(80, 0);
        wr(sel, $urandom_range(1023, 0), y, 1'($urandom_range(3, 0) != 0),
           1'($urandom), 1'($urandom));
      end
      ln = $urandom_range(90, 0);
      wc = ($urandom_range(2, 0) == 0) ? $urandom_range(N, 1) : 0;
      dc = ($urandom_range(3, 0) == 0) ? $urandom_range(N, 2) : 0;
      do_line(ln, wc, $urandom_range(N - 1, 0), $urandom_range(1023, 0), $urandom_range(80, 0),
              1'($urandom), 1'($urandom), 1'($urandom), dc, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
